// File: rtl/led_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_ctrl_pkg
// Brief    : Shared mode encodings, register offsets and field widths.
// Revision : 1.0
// ============================================================================
package led_ctrl_pkg;

    localparam int MODE_W = 2;
    localparam int HALF_W = 16;
    localparam int DUTY_W = 8;
    localparam int REG_W  = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PWM   = 2'b11
    } led_mode_e;

    localparam logic [REG_W-1:0] REG_MODE  = 2'd0;
    localparam logic [REG_W-1:0] REG_HALF  = 2'd1;
    localparam logic [REG_W-1:0] REG_DUTY  = 2'd2;
    localparam logic [REG_W-1:0] REG_STATE = 2'd3;

    // Terminal tick count for a blink half-period; zero is treated as one.
    function automatic logic [HALF_W-1:0] blink_limit(input logic [HALF_W-1:0] half);
        return (half == '0) ? '0 : half - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_channel
// Brief    : One LED channel: mode/half/duty registers, blink counter, output flop.
// Revision : 1.0
// ============================================================================
module led_channel
    import led_ctrl_pkg::*;
#(
    parameter int DEF_HALF = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic              wr_en,
    input  logic [REG_W-1:0]  wr_reg,
    input  logic [HALF_W-1:0] wr_data,
    output logic [MODE_W-1:0] mode,
    output logic [HALF_W-1:0] half,
    output logic [DUTY_W-1:0] duty,
    output logic              led
);

    logic [MODE_W-1:0] r_mode;
    logic [HALF_W-1:0] r_half;
    logic [DUTY_W-1:0] r_duty;
    logic [HALF_W-1:0] r_cnt;
    logic              r_led;
    logic              w_restart;

    // Changing how a channel blinks restarts its period from dark.
    assign w_restart = wr_en && ((wr_reg == REG_MODE) || (wr_reg == REG_HALF));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= MODE_OFF;
            r_half <= HALF_W'(DEF_HALF);
            r_duty <= '0;
            r_cnt  <= '0;
            r_led  <= 1'b0;
        end else begin
            if (wr_en) begin
                case (wr_reg)
                    REG_MODE: r_mode <= wr_data[MODE_W-1:0];
                    REG_HALF: r_half <= wr_data;
                    REG_DUTY: r_duty <= wr_data[DUTY_W-1:0];
                    default:  ;
                endcase
            end

            if (w_restart) begin
                r_cnt <= '0;
                r_led <= 1'b0;
            end else begin
                case (r_mode)
                    MODE_OFF: r_led <= 1'b0;
                    MODE_ON:  r_led <= 1'b1;
                    MODE_BLINK: begin
                        if (tick) begin
                            if (r_cnt == blink_limit(r_half)) begin
                                r_cnt <= '0;
                                r_led <= ~r_led;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    MODE_PWM: r_led <= (pwm_cnt < r_duty);
                    default:  r_led <= 1'b0;
                endcase
            end
        end
    end

    assign mode = r_mode;
    assign half = r_half;
    assign duty = r_duty;
    assign led  = r_led;

endmodule
`default_nettype wire

// File: rtl/led_channel_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : led_channel_ctrl
// Brief    : N_CH LED channels with shared tick prescaler, pwm counter and bus.
// Revision : 1.0
// ============================================================================
module led_channel_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int DEF_HALF = 1000,
    localparam int AW      = $clog2(N_CH) + 2
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    input  logic [AW-1:0]   address,
    input  logic            write,
    input  logic [31:0]     writedata,
    input  logic            read,
    output logic [31:0]     readdata,
    output logic [N_CH-1:0] LEDG
);

    localparam int C_DIV = CLK_HZ / TICK_HZ;
    localparam int C_PW  = $clog2(C_DIV);

    logic [C_PW-1:0]   r_presc;
    logic [DUTY_W-1:0] r_pwm;
    logic [31:0]       r_rdata;
    logic              w_tick;
    logic [31:0]       w_ch_idx;
    logic [REG_W-1:0]  w_reg;
    logic [31:0]       w_rdata;
    logic [N_CH-1:0]   w_wr_en;
    logic [N_CH-1:0]   w_led;
    logic [MODE_W-1:0] w_mode [N_CH];
    logic [HALF_W-1:0] w_half [N_CH];
    logic [DUTY_W-1:0] w_duty [N_CH];
    logic              w_unused_wdata;

    assign w_unused_wdata = ^writedata[31:HALF_W];

    assign w_tick = (r_presc == C_PW'(C_DIV - 1));

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_presc <= '0;
            r_pwm   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_pwm   <= r_pwm + 1'b1;
        end
    end

    // Channel indices beyond N_CH never match any instance, so such writes drop.
    assign w_ch_idx = 32'(address) >> REG_W;
    assign w_reg    = address[REG_W-1:0];

    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign w_wr_en[i] = write && (w_ch_idx == 32'(i)) && (w_reg != REG_STATE);

            led_channel #(
                .DEF_HALF (DEF_HALF)
            ) u_channel (
                .clk     (CLOCK_50),
                .rst     (RESET),
                .tick    (w_tick),
                .pwm_cnt (r_pwm),
                .wr_en   (w_wr_en[i]),
                .wr_reg  (w_reg),
                .wr_data (writedata[HALF_W-1:0]),
                .mode    (w_mode[i]),
                .half    (w_half[i]),
                .duty    (w_duty[i]),
                .led     (w_led[i])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_ch_idx == 32'(i)) begin
                case (w_reg)
                    REG_MODE:  w_rdata = 32'(w_mode[i]);
                    REG_HALF:  w_rdata = 32'(w_half[i]);
                    REG_DUTY:  w_rdata = 32'(w_duty[i]);
                    default:   w_rdata = 32'(w_led[i]);
                endcase
            end
        end
    end

    // Sampled from current register state, so a same-edge write reads old data.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_rdata <= '0;
        end else if (read) begin
            r_rdata <= w_rdata;
        end
    end

    assign readdata = r_rdata;
    assign LEDG     = w_led;

endmodule
`default_nettype wire

// File: tb/tb_led_channel_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_led_channel_ctrl
// Brief    : Directed self-checking bench for led_channel_ctrl (4 channels).
// Revision : 1.0
// ============================================================================
module tb_led_channel_ctrl;

    localparam int N_CH     = 4;
    localparam int CLK_HZ   = 1000;
    localparam int TICK_HZ  = 100;
    localparam int DEF_HALF = 3;
    localparam int AW       = 4;
    localparam int DIV      = CLK_HZ / TICK_HZ;

    logic            CLOCK_50 = 1'b0;
    logic            RESET    = 1'b1;
    logic [AW-1:0]   address  = '0;
    logic            write    = 1'b0;
    logic [31:0]     writedata = '0;
    logic            read     = 1'b0;
    logic [31:0]     readdata;
    logic [N_CH-1:0] LEDG;

    int checks = 0;
    int errors = 0;
    int ncyc;
    logic [31:0] sb [$];

    led_channel_ctrl #(
        .N_CH     (N_CH),
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .DEF_HALF (DEF_HALF)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .LEDG      (LEDG)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Non-reset edges seen so far; the prescaler ticks on edges where this is 9 mod 10.
    always @(posedge CLOCK_50) begin
        if (RESET) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d, output int wedge);
        address   = AW'(ch * 4 + rg);
        writedata = d;
        write     = 1'b1;
        wedge     = ncyc;
        step();
        write     = 1'b0;
    endtask

    task automatic rd(input int ch, input int rg, input logic [31:0] exp, input string tag);
        address = AW'(ch * 4 + rg);
        read    = 1'b1;
        sb.push_back(exp);
        step();
        read    = 1'b0;
        chk(tag, readdata, sb.pop_front());
    endtask

    task automatic read_reset_values(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd(a / 4, a % 4, (a % 4 == 1) ? 32'(DEF_HALF) : 32'd0, tag);
        end
    endtask

    function automatic int next_tick(input int w);
        int t;
        t = w + 1;
        while (t % DIV != DIV - 1) t++;
        return t;
    endfunction

    // Returns the pre-edge cycle index of the edge where LEDG[idx] became val, or -1.
    task automatic wait_led(input int idx, input logic val, input int maxc, output int edge_c);
        edge_c = -1;
        for (int k = 0; k < maxc; k++) begin
            step();
            if (LEDG[idx] === val) begin
                edge_c = ncyc - 1;
                break;
            end
        end
    endtask

    task automatic count_high(input int idx, output int n);
        n = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (LEDG[idx] === 1'b1) n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, e, t, n;
        logic cur;

        repeat (3) step();
        chk("reset_ledg", 32'(LEDG), 32'd0);
        chk("reset_rdata", readdata, 32'd0);
        RESET = 1'b0;
        read_reset_values("reset_regs");
        chk("reset_ledg2", 32'(LEDG), 32'd0);

        wr(2, 0, 32'd1, w);
        chk("on_write_edge", 32'(LEDG), 32'd0);
        step();
        chk("on_ledg", 32'(LEDG), 32'b0100);
        rd(2, 3, 32'd1, "state_on");
        wr(2, 0, 32'd0, w);
        step();
        chk("off_ledg", 32'(LEDG), 32'd0);

        address = AW'(2 * 4 + 1); writedata = 32'd7; write = 1'b1; read = 1'b1;
        sb.push_back(32'd3);
        step();
        write = 1'b0; read = 1'b0;
        chk("rw_prewrite", readdata, sb.pop_front());
        rd(2, 1, 32'd7, "half_readback");
        wr(2, 3, 32'd1, w);
        rd(2, 3, 32'd0, "state_ro");
        rd(2, 0, 32'd0, "state_wr_ignored");
        wr(2, 2, 32'hFFFF_FF40, w);
        rd(2, 2, 32'h40, "duty_zero_ext");

        wr(0, 0, 32'd2, w);
        wr(0, 1, 32'd3, w);
        t = next_tick(w) + 2 * DIV;
        wait_led(0, 1'b1, 100, e);
        chk("blink_rise1", 32'(e), 32'(t));
        wait_led(0, 1'b0, 100, e);
        chk("blink_fall1", 32'(e), 32'(t + 3 * DIV));
        wait_led(0, 1'b1, 100, e);
        chk("blink_rise2", 32'(e), 32'(t + 6 * DIV));

        wr(1, 0, 32'd3, w);
        wr(1, 2, 32'd64, w);
        step();
        count_high(1, n);
        chk("pwm_duty64", 32'(n), 32'd64);
        wr(1, 2, 32'd255, w);
        step();
        count_high(1, n);
        chk("pwm_duty255", 32'(n), 32'd255);
        wr(1, 2, 32'd0, w);
        step();
        count_high(1, n);
        chk("pwm_duty0", 32'(n), 32'd0);

        cur = LEDG[0];
        wait_led(0, ~cur, 100, e);
        chk("ch0_undisturbed", 32'((e - t) % (3 * DIV)), 32'd0);

        wr(0, 1, 32'd0, w);
        t = next_tick(w);
        wait_led(0, 1'b1, 50, e);
        chk("half0_rise", 32'(e), 32'(t));
        wait_led(0, 1'b0, 50, e);
        chk("half0_fall", 32'(e), 32'(t + DIV));
        wait_led(0, 1'b1, 50, e);
        chk("half0_rise2", 32'(e), 32'(t + 2 * DIV));
        repeat (4) step();
        chk("half0_still_high", 32'(LEDG[0]), 32'd1);
        wr(0, 1, 32'd5, w);
        chk("half_wr_clears", 32'(LEDG[0]), 32'd0);
        t = next_tick(w) + 4 * DIV;
        wait_led(0, 1'b1, 100, e);
        chk("half5_rise", 32'(e), 32'(t));

        wr(2, 0, 32'd1, w);
        rd(0, 1, 32'd5, "pre_reset_read");
        chk("pre_reset_ch2", 32'(LEDG[2]), 32'd1);
        RESET = 1'b1;
        address = AW'(3 * 4 + 0); writedata = 32'd1; write = 1'b1;
        step();
        write = 1'b0;
        chk("midreset_ledg", 32'(LEDG), 32'd0);
        chk("midreset_rdata", readdata, 32'd0);
        RESET = 1'b0;
        step();
        chk("postreset_ledg", 32'(LEDG), 32'd0);
        read_reset_values("postreset_regs");
        repeat (3) step();
        chk("postreset_ledg2", 32'(LEDG), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
